// File: rtl/ppc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ppc_pkg                                                |
// | Description : Shared types and constants for the ping-pong counter   |
// |               monitor: error codes, tracker states, default width.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package ppc_pkg;

  localparam int DEF_W = 4;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_VAL  = 2'b01;
  localparam logic [1:0] ERR_DIR  = 2'b10;
  localparam logic [1:0] ERR_RST  = 2'b11;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } ppc_state_e;

endpackage
`default_nettype wire

// File: rtl/ppc_predict.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ppc_predict                                            |
// | Description : Combinational model of one ping-pong counter step.     |
// |               Given the values the counter consumed at an edge, it   |
// |               returns the value/direction the counter must show next |
// |               and whether that step is a hold.                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ppc_predict
  import ppc_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] out,
  input  logic         dir,
  input  logic         en,
  input  logic         flip,
  input  logic [W-1:0] max,
  input  logic [W-1:0] min,
  output logic [W-1:0] nxt_out,
  output logic         nxt_dir,
  output logic         is_hold
);

  logic w_move;

  // Counter only advances when enabled, the window is non-empty and out lies inside it.
  always_comb begin
    w_move  = en && (min < max) && (min <= out) && (out <= max);
    nxt_out = out;
    nxt_dir = dir;
    is_hold = !w_move;
    if (w_move) begin
      if (out == max) begin
        nxt_dir = 1'b0;
      end else if (out == min) begin
        nxt_dir = 1'b1;
      end else begin
        nxt_dir = dir ^ flip;
      end
      nxt_out = nxt_dir ? (out + W'(1)) : (out - W'(1));
    end
  end

endmodule
`default_nettype wire

// File: rtl/ping_pong_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ping_pong_monitor                                      |
// | Description : Passive checker for the ping-pong counter. Samples the |
// |               counter's inputs and outputs every edge, predicts the  |
// |               next observation, flags mismatches and decodes bounce, |
// |               flip and hold events.                                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ping_pong_monitor
  import ppc_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             flip,
  input  logic [W-1:0]     max,
  input  logic [W-1:0]     min,
  input  logic [W-1:0]     out_in,
  input  logic             dir_in,
  input  logic             clear,
  output logic             bounce_top,
  output logic             bounce_bot,
  output logic             flip_seen,
  output logic             hold_seen,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] bounce_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  ppc_state_e       r_state, w_state_nxt;

  logic [W-1:0]     r_prev_out, r_prev_max, r_prev_min;
  logic             r_prev_dir, r_prev_en, r_prev_flip;

  logic [W-1:0]     w_pred_out;
  logic             w_pred_dir, w_pred_hold;

  logic             w_obs_top, w_obs_bot, w_obs_flip;
  logic             w_ev_top, w_ev_bot, w_ev_flip, w_ev_hold;
  logic             w_err_val, w_err_dir, w_err_rst, w_err_any;
  logic [1:0]       w_err_code;

  logic             r_bounce_top, r_bounce_bot, r_flip_seen, r_hold_seen, r_err;
  logic [1:0]       r_err_code;
  logic [CNT_W-1:0] r_bounce_cnt, r_err_cnt;

  // Expected observation, derived from what the counter consumed at the previous edge.
  ppc_predict #(.W(W)) u_predict (
    .out     (r_prev_out),
    .dir     (r_prev_dir),
    .en      (r_prev_en),
    .flip    (r_prev_flip),
    .max     (r_prev_max),
    .min     (r_prev_min),
    .nxt_out (w_pred_out),
    .nxt_dir (w_pred_dir),
    .is_hold (w_pred_hold)
  );

  // Capture the sample the counter consumes at this edge; it becomes the next reference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_out  <= '0;
      r_prev_dir  <= 1'b0;
      r_prev_en   <= 1'b0;
      r_prev_flip <= 1'b0;
      r_prev_max  <= '0;
      r_prev_min  <= '0;
    end else begin
      r_prev_out  <= out_in;
      r_prev_dir  <= dir_in;
      r_prev_en   <= enable;
      r_prev_flip <= flip;
      r_prev_max  <= max;
      r_prev_min  <= min;
    end
  end

  // Tracker state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, mismatch detection and event decode; FAULT skips the compare so the
  // offending sample can serve as the new reference.
  always_comb begin
    w_state_nxt = r_state;
    w_err_val   = 1'b0;
    w_err_dir   = 1'b0;
    w_err_rst   = 1'b0;
    w_ev_top    = 1'b0;
    w_ev_bot    = 1'b0;
    w_ev_flip   = 1'b0;
    w_ev_hold   = 1'b0;
    w_obs_top   = (r_prev_out == r_prev_max) && r_prev_dir && !dir_in;
    w_obs_bot   = (r_prev_out == r_prev_min) && !r_prev_dir && dir_in;
    w_obs_flip  = (dir_in != r_prev_dir) && (r_prev_out != r_prev_max) &&
                  (r_prev_out != r_prev_min);
    case (r_state)
      WAIT: begin
        w_err_rst   = (out_in != min) || !dir_in;
        w_state_nxt = TRACK;
      end
      TRACK: begin
        w_err_val = (out_in != w_pred_out);
        w_err_dir = (dir_in != w_pred_dir);
        if (w_err_val || w_err_dir) begin
          w_state_nxt = FAULT;
        end else begin
          w_ev_top  = w_obs_top;
          w_ev_bot  = w_obs_bot;
          w_ev_flip = w_obs_flip;
          w_ev_hold = w_pred_hold;
        end
      end
      FAULT: begin
        w_ev_top    = w_obs_top;
        w_ev_bot    = w_obs_bot;
        w_ev_flip   = w_obs_flip;
        w_ev_hold   = w_pred_hold;
        w_state_nxt = TRACK;
      end
      default: begin
        w_state_nxt = WAIT;
      end
    endcase
    w_err_any  = w_err_val || w_err_dir || w_err_rst;
    w_err_code = w_err_rst ? ERR_RST : (w_err_val ? ERR_VAL : ERR_DIR);
  end

  // Registered event pulses plus sticky error and saturating counters; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bounce_top <= 1'b0;
      r_bounce_bot <= 1'b0;
      r_flip_seen  <= 1'b0;
      r_hold_seen  <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_bounce_cnt <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_bounce_top <= w_ev_top;
      r_bounce_bot <= w_ev_bot;
      r_flip_seen  <= w_ev_flip;
      r_hold_seen  <= w_ev_hold;
      if (clear) begin
        r_err        <= 1'b0;
        r_err_code   <= ERR_NONE;
        r_bounce_cnt <= '0;
        r_err_cnt    <= '0;
      end else begin
        if (w_err_any) begin
          r_err <= 1'b1;
          if (!r_err) begin
            r_err_code <= w_err_code;
          end
          if (r_err_cnt != c_cnt_max) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
          end
        end
        if ((w_ev_top || w_ev_bot) && (r_bounce_cnt != c_cnt_max)) begin
          r_bounce_cnt <= r_bounce_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bounce_top = r_bounce_top;
  assign bounce_bot = r_bounce_bot;
  assign flip_seen  = r_flip_seen;
  assign hold_seen  = r_hold_seen;
  assign err        = r_err;
  assign err_code   = r_err_code;
  assign bounce_cnt = r_bounce_cnt;
  assign err_cnt    = r_err_cnt;

`ifndef SYNTHESIS
  ap_no_double_bounce: assert property (@(posedge clk) disable iff (!rst_n)
    !(bounce_top && bounce_bot));
`endif

endmodule
`default_nettype wire

// File: tb/tb_ping_pong_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ping_pong_monitor                                   |
// | Description : Self-checking bench for ping_pong_monitor: directed    |
// |               vector table, reset corner cases and a randomized run  |
// |               against a behavioural reference model.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_ping_pong_monitor;

  localparam int W     = 4;
  localparam int CNT_W = 8;
  localparam int SAT   = 255;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0, flip = 1'b0, clear = 1'b0, dir_in = 1'b0;
  logic [W-1:0]     mx = '0, mn = '0, out_in = '0;
  logic             bounce_top, bounce_bot, flip_seen, hold_seen, err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] bounce_cnt, err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit top, bot, flp, hold, err;
    int code, bcnt, ecnt;
  } exp_t;

  typedef struct {
    bit en, fl, clr;
    int mx, mn, o;
    bit d;
    exp_t e;
  } vec_t;

  typedef struct {
    bit en, fl;
    int mx, mn, o;
    bit d;
  } smp_t;

  vec_t tbl[$];
  exp_t zero_exp;

  // Reference model state
  smp_t m_ref;
  bit   m_have_ref, m_skip;
  exp_t m_exp;

  ping_pong_monitor #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .flip       (flip),
    .max        (mx),
    .min        (mn),
    .out_in     (out_in),
    .dir_in     (dir_in),
    .clear      (clear),
    .bounce_top (bounce_top),
    .bounce_bot (bounce_bot),
    .flip_seen  (flip_seen),
    .hold_seen  (hold_seen),
    .err        (err),
    .err_code   (err_code),
    .bounce_cnt (bounce_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp_v);
    end
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    chk({tag, ".bounce_top"}, 32'(bounce_top), int'(e.top));
    chk({tag, ".bounce_bot"}, 32'(bounce_bot), int'(e.bot));
    chk({tag, ".flip_seen"},  32'(flip_seen),  int'(e.flp));
    chk({tag, ".hold_seen"},  32'(hold_seen),  int'(e.hold));
    chk({tag, ".err"},        32'(err),        int'(e.err));
    chk({tag, ".err_code"},   32'(err_code),   e.code);
    chk({tag, ".bounce_cnt"}, 32'(bounce_cnt), e.bcnt);
    chk({tag, ".err_cnt"},    32'(err_cnt),    e.ecnt);
  endtask

  // Drive one cycle of inputs (called at a negedge), check after the edge, return at a negedge.
  task automatic run_cycle(input bit en, input bit fl, input int vmx, input int vmn,
                           input int o, input bit d, input bit clr,
                           input exp_t e, input string tag);
    logic [31:0] t_mx, t_mn, t_o;
    t_mx = vmx; t_mn = vmn; t_o = o;
    enable = en; flip = fl; clear = clr; dir_in = d;
    mx = t_mx[W-1:0]; mn = t_mn[W-1:0]; out_in = t_o[W-1:0];
    @(posedge clk);
    #1;
    check_outs(tag, e);
    @(negedge clk);
  endtask

  task automatic do_reset(input int vmn, input int vmx);
    logic [31:0] t_mx, t_mn;
    t_mx = vmx; t_mn = vmn;
    rst_n = 1'b0; enable = 1'b1; flip = 1'b0; clear = 1'b0; dir_in = 1'b1;
    mx = t_mx[W-1:0]; mn = t_mn[W-1:0]; out_in = t_mn[W-1:0];
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add_row(input bit en, input bit fl, input int vmx, input int vmn,
                         input int o, input bit d, input bit clr,
                         input bit top, input bit bot, input bit flp, input bit hold,
                         input bit er, input int code, input int bcnt, input int ecnt);
    vec_t v;
    v.en = en; v.fl = fl; v.mx = vmx; v.mn = vmn; v.o = o; v.d = d; v.clr = clr;
    v.e.top = top; v.e.bot = bot; v.e.flp = flp; v.e.hold = hold; v.e.err = er;
    v.e.code = code; v.e.bcnt = bcnt; v.e.ecnt = ecnt;
    tbl.push_back(v);
  endtask

  // Counter contract in plain arithmetic.
  function automatic void contract(input smp_t s, output int no, output bit nd, output bit hold);
    hold = !(s.en && (s.mn < s.mx) && (s.o >= s.mn) && (s.o <= s.mx));
    if (hold) begin
      no = s.o;
      nd = s.d;
    end else begin
      if (s.o == s.mx)      nd = 1'b0;
      else if (s.o == s.mn) nd = 1'b1;
      else                  nd = s.d ^ s.fl;
      no = nd ? s.o + 1 : s.o - 1;
    end
  endfunction

  task automatic model_reset();
    m_have_ref = 1'b0;
    m_skip     = 1'b0;
    m_exp      = zero_exp;
  endtask

  // Advance the reference model by one edge with the current sample.
  task automatic model_step(input smp_t cur, input bit clr);
    int po, code;
    bit pd, ph, bad, t, b, f;
    bad = 1'b0; code = 0;
    m_exp.top = 1'b0; m_exp.bot = 1'b0; m_exp.flp = 1'b0; m_exp.hold = 1'b0;
    if (!m_have_ref) begin
      if (cur.o != cur.mn || !cur.d) begin
        bad  = 1'b1;
        code = 3;
      end
      m_have_ref = 1'b1;
    end else begin
      contract(m_ref, po, pd, ph);
      t = (m_ref.o == m_ref.mx) && m_ref.d && !cur.d;
      b = (m_ref.o == m_ref.mn) && !m_ref.d && cur.d;
      f = (cur.d != m_ref.d) && (m_ref.o != m_ref.mx) && (m_ref.o != m_ref.mn);
      if (!m_skip && (po != cur.o || pd != cur.d)) begin
        bad    = 1'b1;
        code   = (po != cur.o) ? 1 : 2;
        m_skip = 1'b1;
      end else begin
        m_exp.top = t; m_exp.bot = b; m_exp.flp = f; m_exp.hold = ph;
        m_skip = 1'b0;
      end
    end
    if (clr) begin
      m_exp.err = 1'b0; m_exp.code = 0; m_exp.bcnt = 0; m_exp.ecnt = 0;
    end else begin
      if (bad) begin
        if (!m_exp.err) m_exp.code = code;
        m_exp.err = 1'b1;
        if (m_exp.ecnt < SAT) m_exp.ecnt++;
      end
      if ((m_exp.top || m_exp.bot) && m_exp.bcnt < SAT) m_exp.bcnt++;
    end
    m_ref = cur;
  endtask

  initial begin
    exp_t e;
    smp_t cur, ctr;
    int c_out, no, r_mn, r_mx, o;
    bit c_dir, nd, nh, en, fl, clr, d;

    zero_exp = '{default: 0};

    // Directed table: bounce, flip, injected value error, degenerate window, clear,
    // direction-only error followed by a value error.
    //      en fl mx mn  o d clr  top bot flp hold err code bcnt ecnt
    add_row(1, 0, 4, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    add_row(1, 0, 4, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    add_row(1, 0, 4, 0, 2, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    add_row(1, 0, 4, 0, 3, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    add_row(1, 0, 4, 0, 4, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    add_row(1, 0, 4, 0, 3, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0);
    add_row(1, 0, 4, 0, 2, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    add_row(1, 0, 4, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    add_row(1, 0, 4, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    add_row(1, 0, 4, 0, 1, 1, 0,  0, 1, 0, 0, 0, 0, 2, 0);
    add_row(1, 1, 4, 0, 2, 1, 0,  0, 0, 0, 0, 0, 0, 2, 0);
    add_row(1, 0, 4, 0, 1, 0, 0,  0, 0, 1, 0, 0, 0, 2, 0);
    add_row(1, 0, 4, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2, 0);
    add_row(1, 0, 4, 0, 1, 1, 0,  0, 1, 0, 0, 0, 0, 3, 0);
    add_row(1, 0, 4, 0, 4, 1, 0,  0, 0, 0, 0, 1, 1, 3, 1);
    add_row(1, 0, 4, 0, 3, 1, 0,  0, 0, 0, 0, 1, 1, 3, 1);
    add_row(1, 0, 4, 0, 4, 1, 0,  0, 0, 0, 0, 1, 1, 3, 1);
    add_row(1, 0, 9, 9, 3, 0, 0,  1, 0, 0, 0, 1, 1, 4, 1);
    add_row(1, 0, 9, 9, 3, 0, 0,  0, 0, 0, 1, 1, 1, 4, 1);
    add_row(1, 0,15, 0, 3, 0, 0,  0, 0, 0, 1, 1, 1, 4, 1);
    add_row(1, 0,15, 0, 2, 0, 0,  0, 0, 0, 0, 1, 1, 4, 1);
    add_row(1, 0,15, 0, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    add_row(1, 0,15, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    add_row(1, 0,15, 0, 1, 1, 0,  0, 1, 0, 0, 0, 0, 1, 0);
    add_row(1, 0,15, 0, 2, 1, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    add_row(1, 0,15, 0, 3, 0, 0,  0, 0, 0, 0, 1, 2, 1, 1);
    add_row(1, 0,15, 0, 4, 0, 0,  0, 0, 0, 0, 1, 2, 1, 1);
    add_row(1, 0,15, 0, 3, 0, 0,  0, 0, 0, 0, 1, 2, 1, 1);
    add_row(1, 0,15, 0, 7, 0, 0,  0, 0, 0, 0, 1, 2, 1, 2);
    add_row(1, 0,15, 0, 6, 0, 0,  0, 0, 0, 0, 1, 2, 1, 2);
    add_row(1, 0,15, 0, 5, 0, 0,  0, 0, 0, 0, 1, 2, 1, 2);

    @(negedge clk);
    do_reset(0, 4);
    check_outs("reset", zero_exp);

    foreach (tbl[i]) begin
      run_cycle(tbl[i].en, tbl[i].fl, tbl[i].mx, tbl[i].mn, tbl[i].o, tbl[i].d,
                tbl[i].clr, tbl[i].e, $sformatf("vec%0d", i));
    end

    // Reset asserted mid-cycle clears every output without waiting for an edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", zero_exp);
    @(negedge clk);
    rst_n = 1'b1;
    run_cycle(1, 0, 15, 0, 0, 1, 0, zero_exp, "rst_wait_ok");
    run_cycle(1, 0, 15, 0, 1, 1, 0, zero_exp, "rst_track_ok");

    // Reset released while the counter shows a value other than min.
    do_reset(0, 15);
    e = zero_exp; e.err = 1'b1; e.code = 3; e.ecnt = 1;
    run_cycle(1, 0, 15, 0, 3, 1, 0, e, "wait_bad");
    run_cycle(1, 0, 15, 0, 4, 1, 1, zero_exp, "clear");

    // Randomized run: a bench-side counter with occasional corrupted observations.
    r_mn = 0; r_mx = 9;
    do_reset(r_mn, r_mx);
    model_reset();
    c_out = r_mn; c_dir = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (i > 0 && $urandom_range(0, 19) == 0) begin
        r_mn = $urandom_range(0, 7);
        r_mx = $urandom_range(0, 15);
      end
      en  = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 4) == 0);
      clr = (i < 400) && ($urandom_range(0, 149) == 0);
      o = c_out; d = c_dir;
      case ($urandom_range(0, 5))
        0:       o = (c_out + $urandom_range(1, 15)) % 16;
        1:       d = !c_dir;
        default: ;
      endcase
      cur.en = en; cur.fl = fl; cur.mx = r_mx; cur.mn = r_mn; cur.o = o; cur.d = d;
      model_step(cur, clr);
      run_cycle(en, fl, r_mx, r_mn, o, d, clr, m_exp, $sformatf("rand%0d", i));
      ctr.en = en; ctr.fl = fl; ctr.mx = r_mx; ctr.mn = r_mn; ctr.o = c_out; ctr.d = c_dir;
      contract(ctr, no, nd, nh);
      c_out = no; c_dir = nd;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
